// File: rtl/atm_pkg.sv
// -----------------------------------------------------------------------------
// atm_pkg
// Shared definitions for the ATM cash path: denomination table and code width,
// stock counter width, and the dispenser state encoding.
// Denomination code 0 is the largest bill (20000) and code 4 the smallest
// (1000), so walking the codes upwards is the greedy order.
// -----------------------------------------------------------------------------
package atm_pkg;

  localparam int N_DENOM  = 5;
  localparam int DENOM_W  = 3;
  localparam int STOCK_W  = 8;
  localparam int AMOUNT_W = 32;

  typedef logic [AMOUNT_W-1:0] amount_t;
  typedef logic [DENOM_W-1:0]  denom_t;
  typedef logic [STOCK_W-1:0]  stock_t;
  typedef stock_t [N_DENOM-1:0] stock_arr_t;

  // Element 0 is the rightmost entry of the concatenation.
  localparam amount_t [N_DENOM-1:0] DENOM = {
    32'd1000, 32'd2000, 32'd5000, 32'd10000, 32'd20000
  };

  localparam denom_t LAST_DENOM = denom_t'(N_DENOM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAN,
    S_ISSUE,
    S_RELEASE,
    S_DONE,
    S_ERROR,
    S_JAMMED
  } disp_state_e;

endpackage

// File: rtl/cash_dispenser_if.sv
// -----------------------------------------------------------------------------
// cash_dispenser_if
// Bundles the controller request, the bill mechanism handshake and the status
// flags of the cash dispenser.
//   master : the environment (ATM controller, bill mechanism, operator)
//   slave  : the cash_dispenser itself
// -----------------------------------------------------------------------------
interface cash_dispenser_if;
  import atm_pkg::*;

  logic    ENTREGAR_DINERO;  // one-cycle dispense request
  amount_t MONTO;            // amount, valid with ENTREGAR_DINERO
  logic    BILL_ACK;         // mechanism acknowledge
  logic    RECARGA;          // refill pulse
  logic    BILL_REQ;         // request one bill of BILL_DENOM
  denom_t  BILL_DENOM;       // denomination code of the requested bill
  logic    BUSY;             // dispenser not idle
  logic    DISPENSE_DONE;    // whole amount delivered (pulse)
  logic    DISPENSE_ERROR;   // amount cannot be dispensed (pulse)
  logic    ATASCO;           // mechanism jam, sticky until reset
  logic    CAJA_VACIA;       // every stock counter is zero

  modport master (
    output ENTREGAR_DINERO, MONTO, BILL_ACK, RECARGA,
    input  BILL_REQ, BILL_DENOM, BUSY, DISPENSE_DONE, DISPENSE_ERROR,
           ATASCO, CAJA_VACIA
  );

  modport slave (
    input  ENTREGAR_DINERO, MONTO, BILL_ACK, RECARGA,
    output BILL_REQ, BILL_DENOM, BUSY, DISPENSE_DONE, DISPENSE_ERROR,
           ATASCO, CAJA_VACIA
  );

endinterface

// File: rtl/bill_inventory.sv
// -----------------------------------------------------------------------------
// bill_inventory
// Five per-denomination stock counters with refill and single-bill decrement,
// plus the registered "cash box empty" flag.
//   clk, rst_n  : clock, asynchronous active-low reset (reloads INIT_STOCK)
//   refill_i    : load every counter with INIT_STOCK (has priority)
//   dec_i       : remove one bill of denomination dec_idx_i
//   stock_o     : current registered stock counters
//   empty_o     : registered, high when all counters are zero
// -----------------------------------------------------------------------------
module bill_inventory
  import atm_pkg::*;
#(
  parameter int INIT_STOCK = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       refill_i,
  input  logic       dec_i,
  input  denom_t     dec_idx_i,
  output stock_arr_t stock_o,
  output logic       empty_o
);

  localparam stock_arr_t FULL_STOCK = {N_DENOM{stock_t'(INIT_STOCK)}};
  localparam logic       EMPTY_RST  = (INIT_STOCK == 0);

  stock_arr_t stock_q, stock_d;
  logic       empty_q, empty_d;

  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    stock_d = stock_q;
    if (refill_i) begin
      stock_d = FULL_STOCK;
    end else if (dec_i) begin
      // The planner never schedules more bills than are in stock, so this
      // cannot wrap below zero.
      stock_d[dec_idx_i] = stock_q[dec_idx_i] - stock_t'(1);
    end
    // Derived from the registered stock, so the flag trails a change by a cycle.
    empty_d = (stock_q == '0);
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stock_q <= FULL_STOCK;
      empty_q <= EMPTY_RST;
    end else begin
      stock_q <= stock_d;
      empty_q <= empty_d;
    end
  end

  assign stock_o = stock_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/cash_dispenser.sv
// -----------------------------------------------------------------------------
// cash_dispenser
// Takes a dispense request (amount) from the ATM controller, plans the bills
// greedily against the available stock, then issues them one at a time to the
// bill mechanism over a four-phase REQ/ACK handshake with a per-edge timeout.
//   CLK    : clock, rising edge
//   RESET  : asynchronous active-low reset
//   bus    : request, mechanism handshake and status flags (slave side)
// -----------------------------------------------------------------------------
module cash_dispenser
  import atm_pkg::*;
#(
  parameter int INIT_STOCK  = 16,
  parameter int MAX_BILLS   = 32,
  parameter int ACK_TIMEOUT = 64
) (
  input logic              CLK,
  input logic              RESET,
  cash_dispenser_if.slave  bus
);

  localparam int TMO_W   = $clog2(ACK_TIMEOUT + 1);
  localparam int TOTAL_W = 7;

  typedef logic [TMO_W-1:0]   tmo_t;
  typedef logic [TOTAL_W-1:0] plan_t;
  typedef plan_t [N_DENOM-1:0] plan_arr_t;

  localparam tmo_t  TMO_LAST    = tmo_t'(ACK_TIMEOUT - 1);
  localparam plan_t MAX_BILLS_C = plan_t'(MAX_BILLS);

  // Returns {found, code} of the lowest denomination code with a pending bill.
  function automatic logic [DENOM_W:0] first_planned(input plan_arr_t p);
    logic   found;
    denom_t code;
    found = 1'b0;
    code  = '0;
    for (int i = N_DENOM - 1; i >= 0; i--) begin
      if (p[i] != '0) begin
        found = 1'b1;
        code  = denom_t'(i);
      end
    end
    return {found, code};
  endfunction

  disp_state_e state_q, state_d;
  amount_t     remaining_q, remaining_d;
  plan_arr_t   plan_q, plan_d;
  stock_arr_t  tent_q, tent_d;
  denom_t      idx_q, idx_d;
  plan_t       total_q, total_d;
  tmo_t        tmo_q, tmo_d;

  logic        bill_req_q, bill_req_d;
  denom_t      bill_denom_q, bill_denom_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        atasco_q, atasco_d;

  stock_arr_t  stock;
  logic        caja_vacia;
  logic        step_ok;
  logic [DENOM_W:0] next_bill;
  logic        inv_dec;
  logic        inv_refill;

  bill_inventory #(
    .INIT_STOCK (INIT_STOCK)
  ) u_inventory (
    .clk       (CLK),
    .rst_n     (RESET),
    .refill_i  (inv_refill),
    .dec_i     (inv_dec),
    .dec_idx_i (idx_q),
    .stock_o   (stock),
    .empty_o   (caja_vacia)
  );

  // A bill leaves the stock only when the mechanism acknowledges it.
  assign inv_dec    = (state_q == S_ISSUE) && bus.BILL_ACK;
  assign inv_refill = (state_q == S_IDLE) && bus.RECARGA && !bus.ENTREGAR_DINERO;

  assign step_ok   = (remaining_q >= DENOM[idx_q]) && (tent_q[idx_q] != '0);
  assign next_bill = first_planned(plan_q);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    plan_d      = plan_q;
    tent_d      = tent_q;
    idx_d       = idx_q;
    total_d     = total_q;
    tmo_d       = tmo_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.ENTREGAR_DINERO) begin
          remaining_d = bus.MONTO;
          plan_d      = '0;
          tent_d      = stock;
          idx_d       = '0;
          total_d     = '0;
          state_d     = S_PLAN;
        end
      end

      S_PLAN: begin
        if (step_ok) begin
          plan_d[idx_q] = plan_q[idx_q] + plan_t'(1);
          tent_d[idx_q] = tent_q[idx_q] - stock_t'(1);
          remaining_d   = remaining_q - DENOM[idx_q];
          total_d       = total_q + plan_t'(1);
          if (total_d > MAX_BILLS_C) begin
            state_d = S_ERROR;
          end
        end else if (idx_q != LAST_DENOM) begin
          idx_d = idx_q + denom_t'(1);
        end else if (remaining_q == '0) begin
          // A zero amount plans no bills and completes without a handshake.
          if (next_bill[DENOM_W]) begin
            idx_d   = next_bill[DENOM_W-1:0];
            tmo_d   = '0;
            state_d = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_ERROR;
        end
      end

      S_ISSUE: begin
        if (bus.BILL_ACK) begin
          plan_d[idx_q] = plan_q[idx_q] - plan_t'(1);
          tmo_d         = '0;
          state_d       = S_RELEASE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_JAMMED;
        end else begin
          tmo_d = tmo_q + tmo_t'(1);
        end
      end

      S_RELEASE: begin
        if (!bus.BILL_ACK) begin
          if (next_bill[DENOM_W]) begin
            idx_d   = next_bill[DENOM_W-1:0];
            tmo_d   = '0;
            state_d = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_JAMMED;
        end else begin
          tmo_d = tmo_q + tmo_t'(1);
        end
      end

      S_DONE:   state_d = S_IDLE;
      S_ERROR:  state_d = S_IDLE;
      S_JAMMED: state_d = S_JAMMED;
      default:  state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so each flag
    // changes on the same edge as the state it belongs to.
    bill_req_d   = (state_d == S_ISSUE);
    bill_denom_d = (state_d == S_ISSUE) ? idx_d : bill_denom_q;
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    error_d      = (state_d == S_ERROR);
    atasco_d     = (state_d == S_JAMMED);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= S_IDLE;
      remaining_q  <= '0;
      // NOTE: the plan and tentative arrays are a handful of flops, not a RAM,
      // so they are reset with everything else and never hold stale values.
      plan_q       <= '0;
      tent_q       <= '0;
      idx_q        <= '0;
      total_q      <= '0;
      tmo_q        <= '0;
      bill_req_q   <= 1'b0;
      bill_denom_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      atasco_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      plan_q       <= plan_d;
      tent_q       <= tent_d;
      idx_q        <= idx_d;
      total_q      <= total_d;
      tmo_q        <= tmo_d;
      bill_req_q   <= bill_req_d;
      bill_denom_q <= bill_denom_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      atasco_q     <= atasco_d;
    end
  end

  assign bus.BILL_REQ       = bill_req_q;
  assign bus.BILL_DENOM     = bill_denom_q;
  assign bus.BUSY           = busy_q;
  assign bus.DISPENSE_DONE  = done_q;
  assign bus.DISPENSE_ERROR = error_q;
  assign bus.ATASCO         = atasco_q;
  assign bus.CAJA_VACIA     = caja_vacia;

endmodule

// File: tb/tb_cash_dispenser.sv
// -----------------------------------------------------------------------------
// tb_cash_dispenser
// Directed bench for cash_dispenser with default parameters. A mechanism
// responder answers each REQ/ACK edge after two cycles when enabled, logs the
// denomination of every requested bill and flags REQ rising over a high ACK.
// -----------------------------------------------------------------------------
module tb_cash_dispenser;
  import atm_pkg::*;

  localparam int RES_NONE = 0;
  localparam int RES_DONE = 1;
  localparam int RES_ERR  = 2;

  logic clk;
  logic rst_n;

  cash_dispenser_if bus ();

  cash_dispenser #(
    .INIT_STOCK  (16),
    .MAX_BILLS   (32),
    .ACK_TIMEOUT (64)
  ) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Mechanism responder state.
  bit     resp_en = 1'b1;
  int     n_req_rise = 0;
  int     n_overlap  = 0;
  int     n_denom_chg = 0;
  denom_t denom_log [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Four-phase responder, evaluated on the falling edge away from the DUT.
  initial begin : responder
    logic   prev_req;
    denom_t prev_denom;
    int     lat;
    prev_req   = 1'b0;
    prev_denom = '0;
    lat        = 0;
    bus.BILL_ACK = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.BILL_ACK = 1'b0;
        prev_req = 1'b0;
        lat = 0;
      end else begin
        if (!prev_req && bus.BILL_REQ) begin
          if (n_req_rise < 64) denom_log[n_req_rise] = bus.BILL_DENOM;
          n_req_rise++;
          if (bus.BILL_ACK) n_overlap++;
        end
        if (prev_req && bus.BILL_REQ && (bus.BILL_DENOM != prev_denom)) n_denom_chg++;
        prev_req   = bus.BILL_REQ;
        prev_denom = bus.BILL_DENOM;
        if (resp_en && (bus.BILL_REQ != bus.BILL_ACK)) begin
          lat++;
          if (lat >= 2) begin
            bus.BILL_ACK = bus.BILL_REQ;
            lat = 0;
          end
        end else begin
          lat = 0;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Issue one request and wait (bounded) for the DONE or ERROR pulse.
  task automatic dispense(input logic [31:0] amt, output int res);
    @(negedge clk);
    bus.ENTREGAR_DINERO = 1'b1;
    bus.MONTO = amt;
    @(negedge clk);
    bus.ENTREGAR_DINERO = 1'b0;
    res = RES_NONE;
    for (int c = 0; c < 2000; c++) begin
      if (bus.DISPENSE_DONE) begin res = RES_DONE; break; end
      if (bus.DISPENSE_ERROR) begin res = RES_ERR; break; end
      @(negedge clk);
    end
  endtask

  task automatic check_stock(input string tag, input int exp);
    for (int i = 0; i < N_DENOM; i++) begin
      check($sformatf("%s_stock%0d", tag, i), 32'(dut.stock[i]), 32'(exp));
    end
  endtask

  initial begin : stimulus
    int res;
    int base;
    int hi;
    rst_n = 1'b0;
    bus.ENTREGAR_DINERO = 1'b0;
    bus.MONTO = '0;
    bus.RECARGA = 1'b0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_req",    32'(bus.BILL_REQ), 0);
    check("rst_denom",  32'(bus.BILL_DENOM), 0);
    check("rst_busy",   32'(bus.BUSY), 0);
    check("rst_done",   32'(bus.DISPENSE_DONE), 0);
    check("rst_err",    32'(bus.DISPENSE_ERROR), 0);
    check("rst_atasco", 32'(bus.ATASCO), 0);
    check("rst_vacia",  32'(bus.CAJA_VACIA), 0);
    check_stock("rst", 16);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- 38000: one bill of each denomination ----
    base = n_req_rise;
    dispense(32'd38000, res);
    check("m38k_result", 32'(res), RES_DONE);
    check("m38k_nbills", 32'(n_req_rise - base), 5);
    if (n_req_rise - base == 5) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("m38k_denom%0d", i), 32'(denom_log[base + i]), 32'(i));
      end
    end
    check("m38k_busy_at_done", 32'(bus.BUSY), 1);
    @(negedge clk);
    check("m38k_done_1cyc", 32'(bus.DISPENSE_DONE), 0);
    check("m38k_busy_after", 32'(bus.BUSY), 0);
    check_stock("m38k", 15);

    // ---- 1500: not a multiple of 1000 ----
    base = n_req_rise;
    dispense(32'd1500, res);
    check("m1500_result", 32'(res), RES_ERR);
    check("m1500_nbills", 32'(n_req_rise - base), 0);
    @(negedge clk);
    check("m1500_err_1cyc", 32'(bus.DISPENSE_ERROR), 0);
    check_stock("m1500", 15);

    // ---- 800000: more than MAX_BILLS bills ----
    base = n_req_rise;
    dispense(32'd800000, res);
    check("m800k_result", 32'(res), RES_ERR);
    check("m800k_nbills", 32'(n_req_rise - base), 0);
    check_stock("m800k", 15);

    // ---- 0: completes with no bill ----
    base = n_req_rise;
    dispense(32'd0, res);
    check("m0_result", 32'(res), RES_DONE);
    check("m0_nbills", 32'(n_req_rise - base), 0);
    check("overlap_after_basic", 32'(n_overlap), 0);
    check("denom_stable_basic", 32'(n_denom_chg), 0);

    // ---- drain the 1000 drawer, then 6000 fails greedily ----
    do_reset();
    for (int k = 0; k < 16; k++) begin
      dispense(32'd1000, res);
      if (res != RES_DONE) check($sformatf("drain_%0d", k), 32'(res), RES_DONE);
    end
    check("drain_stock4", 32'(dut.stock[4]), 0);
    check("drain_stock2", 32'(dut.stock[2]), 16);
    @(negedge clk);
    check("drain_vacia", 32'(bus.CAJA_VACIA), 0);
    base = n_req_rise;
    dispense(32'd6000, res);
    check("m6000_result", 32'(res), RES_ERR);
    check("m6000_nbills", 32'(n_req_rise - base), 0);
    check("m6000_stock2", 32'(dut.stock[2]), 16);
    check("m6000_stock4", 32'(dut.stock[4]), 0);

    // ---- refill in IDLE ----
    @(negedge clk);
    bus.RECARGA = 1'b1;
    @(negedge clk);
    bus.RECARGA = 1'b0;
    @(negedge clk);
    check_stock("refill", 16);

    // ---- jam: mechanism never acknowledges ----
    resp_en = 1'b0;
    base = n_req_rise;
    @(negedge clk);
    bus.ENTREGAR_DINERO = 1'b1;
    bus.MONTO = 32'd2000;
    @(negedge clk);
    bus.ENTREGAR_DINERO = 1'b0;
    for (int c = 0; c < 50 && !bus.BILL_REQ; c++) @(negedge clk);
    check("jam_req_seen", 32'(bus.BILL_REQ), 1);
    check("jam_denom", 32'(bus.BILL_DENOM), 3);
    hi = 0;
    while (bus.BILL_REQ && hi < 200) begin
      hi++;
      @(negedge clk);
    end
    check("jam_req_cycles", 32'(hi), 64);
    check("jam_atasco", 32'(bus.ATASCO), 1);
    check("jam_req_low", 32'(bus.BILL_REQ), 0);
    check("jam_busy", 32'(bus.BUSY), 1);
    bus.ENTREGAR_DINERO = 1'b1;
    bus.MONTO = 32'd1000;
    bus.RECARGA = 1'b1;
    @(negedge clk);
    bus.ENTREGAR_DINERO = 1'b0;
    bus.RECARGA = 1'b0;
    repeat (10) @(negedge clk);
    check("jam_sticky", 32'(bus.ATASCO), 1);
    check("jam_ignore_req", 32'(n_req_rise - base), 1);
    check("jam_stock3", 32'(dut.stock[3]), 16);
    #2 rst_n = 1'b0;
    #1;
    check("jam_rst_atasco", 32'(bus.ATASCO), 0);
    check("jam_rst_busy", 32'(bus.BUSY), 0);
    @(negedge clk);
    rst_n = 1'b1;
    resp_en = 1'b1;
    @(negedge clk);

    // ---- reset during the third bill of 60000 ----
    base = n_req_rise;
    @(negedge clk);
    bus.ENTREGAR_DINERO = 1'b1;
    bus.MONTO = 32'd60000;
    @(negedge clk);
    bus.ENTREGAR_DINERO = 1'b0;
    for (int c = 0; c < 300 && (n_req_rise - base) < 3; c++) @(negedge clk);
    check("m60k_third_req", 32'(n_req_rise - base), 3);
    #2;
    check("m60k_req_high", 32'(bus.BILL_REQ), 1);
    check("m60k_stock0_mid", 32'(dut.stock[0]), 14);
    rst_n = 1'b0;
    #1;
    check("m60k_rst_req", 32'(bus.BILL_REQ), 0);
    check("m60k_rst_busy", 32'(bus.BUSY), 0);
    check("m60k_rst_done", 32'(bus.DISPENSE_DONE), 0);
    check("m60k_rst_atasco", 32'(bus.ATASCO), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_stock("m60k_after", 16);
    check("m60k_idle", 32'(bus.BUSY), 0);
    check("overlap_final", 32'(n_overlap), 0);
    check("denom_stable_final", 32'(n_denom_chg), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cash_dispenser.md
Name: cash_dispenser

Overview:
Downstream stage of the ATM controller. It consumes the one-cycle ENTREGAR_DINERO pulse and the MONTO word from that controller. It splits the amount into bills using greedy, stock-limited planning, then feeds the bill mechanism one bill at a time over a four-phase REQ/ACK handshake. It tracks per-denomination inventory and reports done, error, jam and empty conditions back to the controller and operator logic.

Parameters:
INIT_STOCK, 16, bills loaded per denomination at reset and on RECARGA (max 255)
MAX_BILLS, 32, max bills per transaction (max 63); exceeding it is an error
ACK_TIMEOUT, 64, cycles to wait for each ACK edge before declaring a jam

Ports:
CLK  in  1  single clock, rising edge
RESET  in  1  asynchronous, active-low reset
ENTREGAR_DINERO  in  1  one-cycle dispense request from the ATM controller
MONTO  in  32  amount in colones, sampled only with ENTREGAR_DINERO
BILL_ACK  in  1  handshake acknowledge from the bill mechanism
RECARGA  in  1  refill pulse, honoured in IDLE only
BILL_REQ  out  1  request one bill of denomination BILL_DENOM
BILL_DENOM  out  3  0=20000, 1=10000, 2=5000, 3=2000, 4=1000
BUSY  out  1  high in every state except IDLE
DISPENSE_DONE  out  1  one-cycle pulse, whole amount delivered
DISPENSE_ERROR  out  1  one-cycle pulse, amount cannot be dispensed; no bill issued
ATASCO  out  1  mechanism jam; sticky until RESET
CAJA_VACIA  out  1  all five stock counters are zero

Behaviour:
- Reset (RESET=0, asynchronous): state=IDLE, all stock counters=INIT_STOCK, plan counters=0.
- Reset outputs: BILL_REQ=0, BILL_DENOM=0, BUSY=0, DISPENSE_DONE=0, DISPENSE_ERROR=0, ATASCO=0, CAJA_VACIA=0 (1 if INIT_STOCK=0).
- All outputs are registered.
- IDLE:
  - ENTREGAR_DINERO=1: latch MONTO into remaining, clear plan counters, copy stock into tentative stock, idx=0. Go to PLAN next cycle.
  - RECARGA=1 (without ENTREGAR_DINERO): stock := INIT_STOCK.
  - Both asserted: the request wins and RECARGA is dropped.
  - RECARGA outside IDLE is ignored.
- PLAN, one step per cycle:
  - If remaining >= DENOM[idx] and tentative[idx] > 0: plan[idx]+1, tentative[idx]-1, remaining -= DENOM[idx], total+1.
  - Otherwise, if idx < 4, idx+1.
  - total > MAX_BILLS: go to ERROR.
  - PLAN ends when idx=4 and no step is possible. remaining=0 → ISSUE with idx=0; remaining≠0 → ERROR.
  - Planning is greedy only. An amount solvable only non-greedily is an error.
  - Worst-case PLAN length is MAX_BILLS+5 cycles.
- ISSUE:
  - Skip denominations whose plan count is 0.
  - Drive BILL_DENOM=idx and BILL_REQ=1; hold both stable until BILL_ACK=1.
  - On ACK: stock[idx]-1, plan[idx]-1, BILL_REQ=0, go to RELEASE.
- RELEASE:
  - Wait for BILL_ACK=0.
  - Then go to the next planned bill (ISSUE), or to DONE when all plan counters are 0.
  - BILL_REQ never rises while BILL_ACK=1.
- DONE: DISPENSE_DONE=1 for one cycle, then IDLE.
- ERROR: DISPENSE_ERROR=1 for one cycle, stock unchanged, then IDLE.
- Timeout: a counter restarts on entry to ISSUE or RELEASE. Reaching ACK_TIMEOUT there → JAMMED.
- JAMMED: BILL_REQ=0, ATASCO=1, BUSY=1. All inputs except RESET are ignored; stock keeps bills already counted.
- MONTO=0: PLAN ends immediately with remaining=0 → DONE with no bills, about 6 cycles after the request.
- ENTREGAR_DINERO while BUSY: ignored, no queuing. The controller must not request again before DONE or ERROR.
- Reset mid-dispense: immediate return to reset state. The partial transaction is lost; stock reloads to INIT_STOCK.
- CAJA_VACIA is updated every cycle from the registered stock.

Decomposition:
- Shared package atm_pkg holds:
  - denomination constants DENOM[0..4] (32-bit);
  - denomination code width (3);
  - dispenser state encoding (IDLE, PLAN, ISSUE, RELEASE, DONE, ERROR, JAMMED);
  - stock width (8).
- One natural sub-module: bill_inventory. It holds the five stock counters, the refill and decrement ports, and the CAJA_VACIA reduction.
- Planner, handshake and timeout stay in cash_dispenser.

Test Plan:
- Reset with defaults → all outputs 0, every stock counter = 16, BUSY=0.
- MONTO=38000, ACK responder with 2-cycle latency → five REQs with BILL_DENOM 0,1,2,3,4. Then one DISPENSE_DONE pulse, each stock = 15, REQ never overlaps high ACK.
- MONTO=1500 → DISPENSE_ERROR pulse, BILL_REQ stays 0, stock unchanged. Same response for MONTO=800000 with MAX_BILLS=32 (40 bills needed).
- Drain: sixteen 1000 requests → stock[4]=0. Then MONTO=6000 → DISPENSE_ERROR (greedy takes 5000, 1000 unavailable), stock[2] still 16.
- Responder that never ACKs, MONTO=2000 → BILL_REQ high ACK_TIMEOUT cycles, then ATASCO=1, BILL_REQ=0, BUSY=1. A further ENTREGAR_DINERO is ignored; RESET clears everything.
- RESET asserted during the third bill's REQ phase of MONTO=60000 → outputs zero asynchronously; after release, stock=16 and state IDLE.
